// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two SRAM requesters, the arbiter and the SRAM controller.
// The arbiter uses the slave view; the requester/controller side uses the master view.
interface sram_arbiter_if;
    logic        prog_mode;

    logic        a_req;
    logic        a_we;
    logic [20:0] a_addr;
    logic [7:0]  a_wd;
    logic        a_ack;
    logic [7:0]  a_rd;

    logic        b_req;
    logic        b_we;
    logic [20:0] b_addr;
    logic [7:0]  b_wd;
    logic        b_ack;
    logic [7:0]  b_rd;

    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd;

    logic        busy;
    logic        owner_b;

    modport slave (
        input  prog_mode,
        input  a_req, a_we, a_addr, a_wd,
        output a_ack, a_rd,
        input  b_req, b_we, b_addr, b_wd,
        output b_ack, b_rd,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wd,
        input  mem_rd,
        output busy, owner_b
    );

    modport master (
        output prog_mode,
        output a_req, a_we, a_addr, a_wd,
        input  a_ack, a_rd,
        output b_req, b_we, b_addr, b_wd,
        input  b_ack, b_rd,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wd,
        output mem_rd,
        input  busy, owner_b
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the SRAM access engine: NES core (A) and UART loader (B).
//
// state   | meaning
// IDLE    | pick a winner among eligible requests, latch its command
// ACCESS  | enables/address/data held for ACCESS_CYCLES cycles, read data captured at the end
// RECOVER | one enable-low cycle, owner's ack is high
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 4,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic           clock,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD   = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  streak, streak_n;

    logic        rd_en_q, rd_en_n;
    logic        wr_en_q, wr_en_n;
    logic [20:0] addr_q, addr_n;
    logic [7:0]  wd_q, wd_n;
    logic        owner_q, owner_n;
    logic        a_ack_q, a_ack_n;
    logic        b_ack_q, b_ack_n;
    logic [7:0]  a_rd_q, a_rd_n;
    logic [7:0]  b_rd_q, b_rd_n;

    logic        a_elig;
    logic        b_elig;
    logic        grant_b;
    logic        win_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            streak  <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            owner_q <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            streak  <= streak_n;
            rd_en_q <= rd_en_n;
            wr_en_q <= wr_en_n;
            addr_q  <= addr_n;
            wd_q    <= wd_n;
            owner_q <= owner_n;
            a_ack_q <= a_ack_n;
            b_ack_q <= b_ack_n;
            a_rd_q  <= a_rd_n;
            b_rd_q  <= b_rd_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        streak_n = streak;
        rd_en_n  = rd_en_q;
        wr_en_n  = wr_en_q;
        addr_n   = addr_q;
        wd_n     = wd_q;
        owner_n  = owner_q;
        a_ack_n  = 1'b0;
        b_ack_n  = 1'b0;
        a_rd_n   = a_rd_q;
        b_rd_n   = b_rd_q;

        a_elig  = bus.a_req && !bus.prog_mode;
        b_elig  = bus.b_req;
        // B only overrides an eligible A once A has used up its streak allowance.
        grant_b = b_elig && (!a_elig || (streak == STREAK_MAX));
        win_we  = grant_b ? bus.b_we : bus.a_we;

        unique case (state)
            IDLE: begin
                if (a_elig || b_elig) begin
                    state_n = ACCESS;
                    cnt_n   = CNT_LOAD;
                    owner_n = grant_b;
                    addr_n  = grant_b ? bus.b_addr : bus.a_addr;
                    wd_n    = grant_b ? bus.b_wd : bus.a_wd;
                    rd_en_n = !win_we;
                    wr_en_n = win_we;
                    if (grant_b || !bus.b_req) begin
                        streak_n = '0;
                    end else if (streak != STREAK_MAX) begin
                        streak_n = streak + 4'd1;
                    end
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    if (rd_en_q) begin
                        if (owner_q) begin
                            b_rd_n = bus.mem_rd;
                        end else begin
                            a_rd_n = bus.mem_rd;
                        end
                    end
                    rd_en_n = 1'b0;
                    wr_en_n = 1'b0;
                    a_ack_n = !owner_q;
                    b_ack_n = owner_q;
                    state_n = RECOVER;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RECOVER: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_wr_en = wr_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wd    = wd_q;
    assign bus.owner_b   = owner_q;
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_rd      = a_rd_q;
    assign bus.b_rd      = b_rd_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: timeline reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sram_arbiter;
    localparam int AC = 4;
    localparam int SL = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sram_arbiter_if bus();

    sram_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: each grant at cycle g owns cycles g+1..g+AC+1 ----------------
    int          cyc = 0;
    bit          model_valid = 0;
    bit          m_have = 0;
    int          m_g = 0;
    int          m_free = 0;
    int          m_streak = 0;
    bit          m_owner = 0;
    bit          m_we = 0;
    logic [20:0] m_addr = '0;
    logic [7:0]  m_wd = '0;
    logic [7:0]  m_ard = '0;
    logic [7:0]  m_brd = '0;
    bit          ae, be, win_b, in_en, ack_c;
    int          c;

    bit          e_rd_en, e_wr_en, e_a_ack, e_b_ack, e_busy, e_owner;
    logic [20:0] e_addr;
    logic [7:0]  e_wd, e_ard, e_brd;

    // directed-scenario monitors
    int          mon_rd_en = 0, mon_wr_en = 0, mon_match = 0;
    int          mon_a_ack = 0, mon_b_ack = 0, mon_long_run = 0;
    int          run_len = 0;
    bit          mon_grants[$];
    logic [20:0] ref_addr = '0;
    logic [7:0]  ref_wd = '0;
    bit          ref_owner = 0;

    always @(negedge clock) begin
        if (model_valid) begin
            chk("a_ack",     32'(bus.a_ack),     32'(e_a_ack));
            chk("b_ack",     32'(bus.b_ack),     32'(e_b_ack));
            chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_rd_en));
            chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(e_wr_en));
            chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
            chk("mem_wd",    32'(bus.mem_wd),    32'(e_wd));
            chk("busy",      32'(bus.busy),      32'(e_busy));
            chk("owner_b",   32'(bus.owner_b),   32'(e_owner));
            chk("a_rd",      32'(bus.a_rd),      32'(e_ard));
            chk("b_rd",      32'(bus.b_rd),      32'(e_brd));
        end

        if (bus.mem_rd_en === 1'b1) mon_rd_en++;
        if (bus.mem_wr_en === 1'b1) mon_wr_en++;
        if ((bus.mem_rd_en || bus.mem_wr_en) && bus.mem_addr == ref_addr &&
            bus.mem_wd == ref_wd && bus.owner_b == ref_owner) mon_match++;
        if (bus.a_ack === 1'b1) mon_a_ack++;
        if (bus.b_ack === 1'b1) mon_b_ack++;
        if (bus.mem_rd_en || bus.mem_wr_en) begin
            if (run_len == 0) mon_grants.push_back(bus.owner_b);
            run_len++;
            if (run_len > AC) mon_long_run++;
        end else begin
            run_len = 0;
        end

        if (reset) begin
            m_have = 0; m_free = cyc + 1; m_streak = 0;
            m_owner = 0; m_we = 0; m_addr = '0; m_wd = '0; m_ard = '0; m_brd = '0;
            model_valid = 1;
        end else begin
            if (m_have && cyc == m_g + AC && !m_we) begin
                if (m_owner) m_brd = bus.mem_rd; else m_ard = bus.mem_rd;
            end
            if (cyc >= m_free) begin
                ae = bus.a_req && !bus.prog_mode;
                be = bus.b_req;
                if (ae || be) begin
                    win_b = be && (!ae || m_streak == SL);
                    if (!win_b && bus.b_req) m_streak = (m_streak < SL) ? m_streak + 1 : SL;
                    else m_streak = 0;
                    m_have  = 1;
                    m_g     = cyc;
                    m_free  = cyc + AC + 2;
                    m_owner = win_b;
                    m_we    = win_b ? bus.b_we : bus.a_we;
                    m_addr  = win_b ? bus.b_addr : bus.a_addr;
                    m_wd    = win_b ? bus.b_wd : bus.a_wd;
                end
            end
        end

        c       = cyc + 1;
        in_en   = m_have && c >= m_g + 1 && c <= m_g + AC;
        ack_c   = m_have && c == m_g + AC + 1;
        e_rd_en = in_en && !m_we;
        e_wr_en = in_en && m_we;
        e_a_ack = ack_c && !m_owner;
        e_b_ack = ack_c && m_owner;
        e_busy  = m_have && c >= m_g + 1 && c <= m_g + AC + 1;
        e_owner = m_owner;
        e_addr  = m_addr;
        e_wd    = m_wd;
        e_ard   = m_ard;
        e_brd   = m_brd;
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        mon_rd_en = 0; mon_wr_en = 0; mon_match = 0;
        mon_a_ack = 0; mon_b_ack = 0; mon_long_run = 0;
        mon_grants.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Returns at the cycle carrying the n-th ack (of either port).
    task automatic run_acks(input int n, input string name);
        int seen = 0;
        for (int i = 0; i < n * (AC + 2) + 40 && seen < n; i++) begin
            tick();
            if (bus.a_ack || bus.b_ack) seen++;
        end
        if (seen < n) begin
            nvec++;
            nfail++;
            $display("FAIL %s: only %0d of %0d acks before timeout", name, seen, n);
        end
    endtask

    bit exp_order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit pend_a, pend_b;

    initial begin
        bus.prog_mode = 0;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wd = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wd = '0;
        bus.mem_rd = 8'h5A;
        do_reset();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_owner_b", 32'(bus.owner_b), 32'd0);

        // single A read
        clear_mon();
        ref_addr = 21'h01234; ref_wd = 8'h00; ref_owner = 0;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 21'h01234; bus.a_wd = 8'h00;
        run_acks(1, "a_read_ack");
        bus.a_req = 0;
        tick(); tick();
        chk("a_read_en_cycles", 32'(mon_match), 32'd4);
        chk("a_read_rd_en_total", 32'(mon_rd_en), 32'd4);
        chk("a_read_a_acks", 32'(mon_a_ack), 32'd1);
        chk("a_read_b_acks", 32'(mon_b_ack), 32'd0);
        chk("a_read_data", 32'(bus.a_rd), 32'h5A);

        // B write
        clear_mon();
        ref_addr = 21'h1F000; ref_wd = 8'hC3; ref_owner = 1;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 21'h1F000; bus.b_wd = 8'hC3;
        run_acks(1, "b_write_ack");
        bus.b_req = 0;
        tick(); tick();
        chk("b_write_en_cycles", 32'(mon_match), 32'd4);
        chk("b_write_wr_en_total", 32'(mon_wr_en), 32'd4);
        chk("b_write_b_acks", 32'(mon_b_ack), 32'd1);
        chk("b_write_a_acks", 32'(mon_a_ack), 32'd0);
        chk("b_write_b_rd_kept", 32'(bus.b_rd), 32'h00);

        // both held: starvation limit
        do_reset();
        clear_mon();
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 21'h00100;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 21'h00200;
        run_acks(8, "starve_acks");
        bus.a_req = 0; bus.b_req = 0;
        tick(); tick();
        chk("starve_grant_count", 32'(mon_grants.size()), 32'd8);
        for (int i = 0; i < 8 && i < mon_grants.size(); i++)
            chk($sformatf("starve_grant_%0d", i), 32'(mon_grants[i]), 32'(exp_order[i]));
        chk("starve_enable_gap", 32'(mon_long_run), 32'd0);

        // prog_mode: B only, then A once released
        do_reset();
        clear_mon();
        bus.prog_mode = 1;
        bus.a_req = 1; bus.b_req = 1;
        run_acks(3, "prog_b_acks");
        bus.prog_mode = 0;
        run_acks(1, "prog_a_ack");
        bus.a_req = 0; bus.b_req = 0;
        tick(); tick();
        chk("prog_grant_count", 32'(mon_grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < mon_grants.size(); i++)
            chk($sformatf("prog_grant_%0d", i), 32'(mon_grants[i]), (i < 3) ? 32'd1 : 32'd0);
        chk("prog_b_acks", 32'(mon_b_ack), 32'd3);
        chk("prog_a_acks", 32'(mon_a_ack), 32'd1);

        // reset in the 2nd ACCESS cycle
        clear_mon();
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 21'h00ABC;
        for (int i = 0; i < 10 && !bus.mem_rd_en; i++) tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_a_ack", 32'(bus.a_ack), 32'd0);
        chk("rst_mid_no_ack_yet", 32'(mon_a_ack), 32'd0);
        clear_mon();
        run_acks(1, "rst_regrant_ack");
        bus.a_req = 0;
        tick();
        chk("rst_regrant_window", 32'(mon_rd_en), 32'd4);
        chk("rst_regrant_acks", 32'(mon_a_ack), 32'd1);

        // a_req left high after the ack: second transaction
        clear_mon();
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 21'h00777; bus.a_wd = 8'h3C;
        run_acks(2, "held_req_acks");
        bus.a_req = 0;
        tick(); tick();
        chk("held_req_a_acks", 32'(mon_a_ack), 32'd2);
        chk("held_req_wr_cycles", 32'(mon_wr_en), 32'd8);

        // randomized traffic against the model
        pend_a = 0; pend_b = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            bus.mem_rd = 8'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) bus.prog_mode = !bus.prog_mode;
            if (pend_a) begin
                if (bus.a_ack && $urandom_range(0, 3) != 0) begin
                    bus.a_req = 0; pend_a = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.a_req = 1; pend_a = 1;
                bus.a_we = 1'($urandom); bus.a_addr = 21'($urandom); bus.a_wd = 8'($urandom);
            end
            if (pend_b) begin
                if (bus.b_ack && $urandom_range(0, 3) != 0) begin
                    bus.b_req = 0; pend_b = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.b_req = 1; pend_b = 1;
                bus.b_we = 1'($urandom); bus.b_addr = 21'($urandom); bus.b_wd = 8'($urandom);
            end
        end
        reset = 1'b0;
        bus.a_req = 0; bus.b_req = 0; bus.prog_mode = 0;
        for (int i = 0; i < 10; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
